// File: rtl/reg_dump_reader.sv
// Debug dump reader: walks register indices 0..NREGS-1 on read port A and streams each word
// over a valid/ready link. Optional trailing checksum word when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] a,
  output logic [AW-1:0] ra,
  output logic          own,
  output logic [DW-1:0] dout,
  output logic          valid,
  input  logic          ready,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM,
`endif
    FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DW-1:0] sum;
`endif

  // The address register doubles as the port A address; it only matters while own=1.
  assign ra = idx;

  // NOTE: every register here is state, so all assignments are non-blocking and the
  // whole set is cleared by the asynchronous reset, not on the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      own   <= 1'b0;
      dout  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      sum   <= '0;
`endif
    end else if (state != IDLE && abort) begin
      // Abort wins over ready: an accept on this edge is simply dropped.
      state <= IDLE;
      idx   <= '0;
      own   <= 1'b0;
      valid <= 1'b0;
      last  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= LOAD;
            idx   <= '0;
            own   <= 1'b1;
            busy  <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end

        LOAD: begin
          dout  <= a;
          valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          sum   <= sum + a;
          last  <= 1'b0;
`else
          last  <= (idx == LAST_IDX);
`endif
          state <= SEND;
        end

        SEND: begin
          if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state <= CSUM;
              dout  <= sum;
              valid <= 1'b1;
              last  <= 1'b1;
`else
              state <= FIN;
              own   <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            own   <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
`endif

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: full dumps, stall, abort, async reset, ignored START.
// Expected stream is derived from the bench's own register file model at stimulus time.
module tb_reg_dump_reader;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] a;
  logic [AW-1:0] ra;
  logic          own, valid, last, busy, done;
  logic [DW-1:0] dout;

  logic [DW-1:0] regfile [NREGS];
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t sb[$];

  reg_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .ra(ra), .own(own),
    .dout(dout), .valid(valid), .ready(ready), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always_comb a = regfile[ra];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_dump();
    exp_t e;
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < NREGS; i++) begin
      e.data = regfile[i];
      s += regfile[i];
`ifdef REG_DUMP_CHECKSUM_EN
      e.last = 1'b0;
`else
      e.last = (i == NREGS - 1);
`endif
      sb.push_back(e);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    e.data = s;
    e.last = 1'b1;
    sb.push_back(e);
`endif
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ra, own, dout, valid, last, busy, done} !== '0)
      $display("FAIL reset_now outputs=%h exp 0", {ra, own, dout, valid, last, busy, done});
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ra, own, dout, valid, last, busy, done} !== '0)
      $display("FAIL reset_idle outputs=%h exp 0", {ra, own, dout, valid, last, busy, done});
    else passes++;
  endtask

  task automatic test_full_dump(input bit mid_start);
    exp_t e;
    bit   ok;
    int   n;
    push_dump();
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({own, busy, valid} !== 3'b110)
      $display("FAIL load_state own/busy/valid=%b exp 110", {own, busy, valid});
    else passes++;
    n = 0;
    while (sb.size() > 0) begin
      wait_valid(ok);
      if (!ok) begin
        checks++;
        $display("FAIL full_timeout word %0d valid=%b exp 1", n, valid);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      checks++;
      if (dout !== e.data) $display("FAIL full_data word %0d got %h exp %h", n, dout, e.data);
      else passes++;
      checks++;
      if (last !== e.last) $display("FAIL full_last word %0d got %b exp %b", n, last, e.last);
      else passes++;
      checks++;
      if ({own, busy} !== 2'b11) $display("FAIL full_own word %0d own/busy=%b exp 11", n, {own, busy});
      else passes++;
      start = mid_start && (n == 10);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    checks++;
    if ({done, own, valid, busy} !== 4'b1001)
      $display("FAIL fin_state done/own/valid/busy=%b exp 1001", {done, own, valid, busy});
    else passes++;
    @(negedge clk);
    checks++;
    if ({done, busy, own} !== 3'b000)
      $display("FAIL fin_after done/busy/own=%b exp 000", {done, busy, own});
    else passes++;
    repeat (4) @(negedge clk);
    checks++;
    if ({valid, done, busy} !== 3'b000)
      $display("FAIL no_extra valid/done/busy=%b exp 000", {valid, done, busy});
    else passes++;
  endtask

  task automatic test_stall();
    exp_t e;
    bit   ok;
    int   n;
    push_dump();
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sb.size() > 0) begin
      if (n == 5) ready = 1'b0;
      wait_valid(ok);
      if (!ok) begin
        checks++;
        $display("FAIL stall_timeout word %0d valid=%b exp 1", n, valid);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      if (n == 5) begin
        repeat (10) begin
          checks++;
          if ({valid, dout} !== {1'b1, e.data})
            $display("FAIL stall_hold valid=%b dout=%h exp 1 %h", valid, dout, e.data);
          else passes++;
          @(negedge clk);
        end
        ready = 1'b1;
      end
      checks++;
      if (dout !== e.data) $display("FAIL stall_data word %0d got %h exp %h", n, dout, e.data);
      else passes++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) $display("FAIL stall_done got %b exp 1", done);
    else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    exp_t e;
    bit   ok;
    push_dump();
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      wait_valid(ok);
      if (!ok) begin
        checks++;
        $display("FAIL abort_timeout word %0d valid=%b exp 1", n, valid);
        break;
      end
      e = sb.pop_front();
      checks++;
      if (dout !== e.data) $display("FAIL abort_data word %0d got %h exp %h", n, dout, e.data);
      else passes++;
      if (n < 7) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({valid, own, busy, done} !== 4'b0000)
      $display("FAIL abort_state valid/own/busy/done=%b exp 0000", {valid, own, busy, done});
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, done, busy} !== 3'b000)
      $display("FAIL abort_quiet valid/done/busy=%b exp 000", {valid, done, busy});
    else passes++;
    sb.delete();
  endtask

  task automatic test_async_reset();
    bit ok;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      wait_valid(ok);
      @(negedge clk);
    end
    wait_valid(ok);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ra, own, dout, valid, last, busy, done} !== '0)
      $display("FAIL async_reset outputs=%h exp 0", {ra, own, dout, valid, last, busy, done});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({own, valid, busy, done} !== 4'b0000)
      $display("FAIL post_reset own/valid/busy/done=%b exp 0000", {own, valid, busy, done});
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regfile[i] = 32'h100 + i;
    test_reset();
    test_full_dump(1'b1);
    test_stall();
    test_abort();
    test_full_dump(1'b0);
    for (int i = 0; i < NREGS; i++) regfile[i] = $urandom;
    test_full_dump(1'b1);
    test_async_reset();
    for (int i = 0; i < NREGS; i++) regfile[i] = 32'h100 + i;
    test_full_dump(1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
